// File: rtl/mem_access_unit.sv
// MEM-stage access unit: posted store buffer, blocking loads, registered
// writeback slot and optional misalignment detection. The memory controller
// port is shared between store draining and loads by a small FSM.
module mem_access_unit #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned REG_AW      = 5,
  parameter int unsigned SB_DEPTH    = 4,
  parameter int unsigned CHECK_ALIGN = 1
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              req_valid_in,
  input  logic [5:0]        op_in,
  input  logic              wr_reg_in,
  input  logic [ADDR_W-1:0] addr_in,
  input  logic [XLEN-1:0]   data_in,
  input  logic [REG_AW-1:0] rd_addr_in,
  output logic              stall_out,
  output logic              mc_req_out,
  output logic              mc_we_out,
  output logic [2:0]        mc_width_out,
  output logic [ADDR_W-1:0] mc_addr_out,
  output logic [XLEN-1:0]   mc_wdata_out,
  input  logic              mc_busy_in,
  input  logic              mc_done_in,
  input  logic [XLEN-1:0]   mc_rdata_in,
  output logic              wb_valid_out,
  output logic              wb_we_out,
  output logic [REG_AW-1:0] wb_addr_out,
  output logic [XLEN-1:0]   wb_value_out,
  output logic              misalign_out,
  output logic              sb_empty_out
);

  localparam int unsigned PTR_W = $clog2(SB_DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(SB_DEPTH);

  localparam logic [5:0] OP_LB  = 6'h01;
  localparam logic [5:0] OP_LH  = 6'h02;
  localparam logic [5:0] OP_LW  = 6'h03;
  localparam logic [5:0] OP_LBU = 6'h04;
  localparam logic [5:0] OP_LHU = 6'h05;
  localparam logic [5:0] OP_SB  = 6'h06;
  localparam logic [5:0] OP_SH  = 6'h07;
  localparam logic [5:0] OP_SW  = 6'h08;

  typedef enum logic [1:0] {IDLE, LD_WAIT, ST_WAIT} state_t;
  state_t state, state_next;

  logic [ADDR_W-1:0] sb_addr  [SB_DEPTH];
  logic [2:0]        sb_width [SB_DEPTH];
  logic [XLEN-1:0]   sb_data  [SB_DEPTH];
  logic [PTR_W-1:0]  sb_wr_ptr, sb_rd_ptr;
  logic [CNT_W-1:0]  sb_count;

  logic              ld_pending, ld_wr;
  logic [5:0]        ld_op;
  logic [2:0]        ld_width;
  logic [ADDR_W-1:0] ld_addr;
  logic [REG_AW-1:0] ld_rd;

  logic              is_load, is_store, misaligned;
  logic [2:0]        width;
  logic [XLEN-1:0]   store_data, ld_value;
  logic              sb_full, deq, enq, accept, ld_accept, ld_done;

  // Opcode decode, access width, store-data masking and alignment check
  always_comb begin
    is_load    = 1'b0;
    is_store   = 1'b0;
    width      = 3'b000;
    misaligned = 1'b0;
    case (op_in)
      OP_LB, OP_LBU: begin is_load = 1'b1;  width = 3'b001; end
      OP_LH, OP_LHU: begin is_load = 1'b1;  width = 3'b010; end
      OP_LW:         begin is_load = 1'b1;  width = 3'b100; end
      OP_SB:         begin is_store = 1'b1; width = 3'b001; end
      OP_SH:         begin is_store = 1'b1; width = 3'b010; end
      OP_SW:         begin is_store = 1'b1; width = 3'b100; end
      default: ;
    endcase
    if (CHECK_ALIGN != 0)
      misaligned = (width == 3'b100 && addr_in[1:0] != 2'b00) ||
                   (width == 3'b010 && addr_in[0]);
    case (width)
      3'b001:  store_data = XLEN'(data_in[7:0]);
      3'b010:  store_data = XLEN'(data_in[15:0]);
      default: store_data = XLEN'(data_in[31:0]);
    endcase
  end

  // Load data extension according to the pending load opcode
  always_comb begin
    case (ld_op)
      OP_LB:   ld_value = XLEN'($signed(mc_rdata_in[7:0]));
      OP_LBU:  ld_value = XLEN'(mc_rdata_in[7:0]);
      OP_LH:   ld_value = XLEN'($signed(mc_rdata_in[15:0]));
      OP_LHU:  ld_value = XLEN'(mc_rdata_in[15:0]);
      default: ld_value = XLEN'($signed(mc_rdata_in[31:0]));
    endcase
  end

  // Handshake: a full buffer only stalls a store if no drain completes now
  always_comb begin
    sb_full   = (sb_count == CNT_FULL);
    deq       = (state == ST_WAIT) && mc_done_in;
    ld_done   = (state == LD_WAIT) && mc_done_in;
    stall_out = ld_pending ||
                (req_valid_in && is_store && !misaligned && sb_full && !deq);
    accept    = req_valid_in && !stall_out;
    enq       = accept && is_store && !misaligned;
    ld_accept = accept && is_load && !misaligned;
    sb_empty_out = (sb_count == '0);
  end

  // Controller FSM next state and request outputs; stores drain before loads
  always_comb begin
    state_next   = state;
    mc_req_out   = 1'b0;
    mc_we_out    = 1'b0;
    mc_width_out = '0;
    mc_addr_out  = '0;
    mc_wdata_out = '0;
    case (state)
      IDLE: begin
        if (!rst_in && !mc_busy_in) begin
          if (ld_pending && sb_count == '0) begin
            mc_req_out   = 1'b1;
            mc_width_out = ld_width;
            mc_addr_out  = ld_addr;
            state_next   = LD_WAIT;
          end else if (sb_count != '0) begin
            mc_req_out   = 1'b1;
            mc_we_out    = 1'b1;
            mc_width_out = sb_width[sb_rd_ptr];
            mc_addr_out  = sb_addr[sb_rd_ptr];
            mc_wdata_out = sb_data[sb_rd_ptr];
            state_next   = ST_WAIT;
          end
        end
      end
      LD_WAIT: if (mc_done_in) state_next = IDLE;
      ST_WAIT: if (mc_done_in) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM state register
  always_ff @(posedge clk_in) begin
    if (rst_in) state <= IDLE;
    else        state <= state_next;
  end

  // Store buffer payload; contents need no reset since count gates them
  always_ff @(posedge clk_in) begin
    if (enq) begin
      sb_addr[sb_wr_ptr]  <= addr_in;
      sb_width[sb_wr_ptr] <= width;
      sb_data[sb_wr_ptr]  <= store_data;
    end
  end

  // Store buffer pointers and occupancy
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      sb_wr_ptr <= '0;
      sb_rd_ptr <= '0;
      sb_count  <= '0;
    end else begin
      if (enq) sb_wr_ptr <= sb_wr_ptr + PTR_W'(1);
      if (deq) sb_rd_ptr <= sb_rd_ptr + PTR_W'(1);
      case ({enq, deq})
        2'b10:   sb_count <= sb_count + CNT_W'(1);
        2'b01:   sb_count <= sb_count - CNT_W'(1);
        default: ;
      endcase
    end
  end

  // Pending load capture, released when its data returns
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      ld_pending <= 1'b0;
      ld_wr      <= 1'b0;
      ld_op      <= '0;
      ld_width   <= '0;
      ld_addr    <= '0;
      ld_rd      <= '0;
    end else if (ld_accept) begin
      ld_pending <= 1'b1;
      ld_wr      <= wr_reg_in;
      ld_op      <= op_in;
      ld_width   <= width;
      ld_addr    <= addr_in;
      ld_rd      <= rd_addr_in;
    end else if (ld_done) begin
      ld_pending <= 1'b0;
    end
  end

  // Writeback slot and misalignment pulse; a load completion cannot coincide
  // with an accept because the pending load stalls upstream
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      wb_valid_out <= 1'b0;
      wb_we_out    <= 1'b0;
      wb_addr_out  <= '0;
      wb_value_out <= '0;
      misalign_out <= 1'b0;
    end else begin
      wb_valid_out <= 1'b0;
      misalign_out <= 1'b0;
      if (ld_done) begin
        wb_valid_out <= 1'b1;
        wb_we_out    <= ld_wr;
        wb_addr_out  <= ld_rd;
        wb_value_out <= ld_value;
      end else if (accept && !ld_accept) begin
        wb_valid_out <= 1'b1;
        wb_we_out    <= wr_reg_in && !is_load && !is_store;
        wb_addr_out  <= rd_addr_in;
        wb_value_out <= data_in;
        misalign_out <= misaligned;
      end
    end
  end

endmodule
